// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern detector: state encoding, default
// parameter values and the fill-counter width helper.
// No logic; latency and backpressure do not apply.
package serial_pattern_pkg;

   // State encoding of the detector FSM
   localparam logic FILL  = 1'b0;
   localparam logic ARMED = 1'b1;

   typedef enum logic {
      ST_FILL  = FILL,
      ST_ARMED = ARMED
   } state_t;

   // Default window and counter sizes
   localparam int DEF_WIDTH   = 4;
   localparam int DEF_COUNT_W = 8;

   // Bits needed to count from 0 up to and including width
   function automatic int fill_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones and never wraps.
// Latency: count updates on the edge that samples inc or sync_clr.
// Backpressure: none; inc is accepted every cycle, sync_clr wins over inc.
//
// Ports:
//   clock     rising-edge clock
//   clear     asynchronous active-low reset, count -> 0
//   inc       add one unless already saturated
//   sync_clr  synchronous clear to 0, priority over inc
//   count     current count
module sat_counter #(
   parameter int COUNT_W = serial_pattern_pkg::DEF_COUNT_W
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               inc,
   input  logic               sync_clr,
   output logic [COUNT_W-1:0] count
);

   localparam logic [COUNT_W-1:0] MAX_CNT = {COUNT_W{1'b1}};

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         count <= '0;
      end else if (sync_clr) begin
         count <= '0;
      end else if (inc && (count != MAX_CNT)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: MSB-first shift window compared against a loaded
// pattern, overlapping matches, one-cycle match pulse, saturating match count.
// Latency: match/match_count one edge after the completing bit; backpressure: none.
//
// Ports:
//   clock        rising-edge clock
//   clear        asynchronous active-low reset
//   bit_in       serial data bit
//   bit_valid    bit_in is sampled when high
//   pattern      target pattern, pattern[WIDTH-1] is the oldest bit
//   load         capture pattern and restart detection (wins over bit_valid)
//   match        registered one-cycle pulse per match
//   match_count  saturating number of matches since reset/load
//   window       shift window, window[0] is the newest bit
//   armed        high once WIDTH valid bits have arrived since reset/load
module serial_pattern_detector
   import serial_pattern_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int COUNT_W = DEF_COUNT_W
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               bit_in,
   input  logic               bit_valid,
   input  logic [WIDTH-1:0]   pattern,
   input  logic               load,
   output logic               match,
   output logic [COUNT_W-1:0] match_count,
   output logic [WIDTH-1:0]   window,
   output logic               armed
);

   localparam int FILL_W = fill_cnt_w(WIDTH);
   localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [WIDTH-1:0]   pattern_reg;
   logic [WIDTH-1:0]   next_window;
   logic               completing;
   logic               hit;
   logic               match_d;

   assign next_window = {window[WIDTH-2:0], bit_in};

   // State register and fill counter
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= ST_FILL;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
      end
   end

   // Next state, completion detect and match decision
   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      completing = 1'b0;
      hit        = 1'b0;
      match_d    = 1'b0;

      unique case (state_q)
         ST_FILL: begin
            // The WIDTH-th bit is the first one that can produce a match
            completing = (fill_q == LAST_FILL);
            if (bit_valid) begin
               fill_d = fill_q + 1'b1;
               if (completing) begin
                  state_d = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            completing = 1'b1;
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase

      hit = bit_valid && completing && (next_window == pattern_reg);

      // load restarts detection and discards the bit sampled alongside it
      if (load) begin
         state_d = ST_FILL;
         fill_d  = '0;
         hit     = 1'b0;
      end

      match_d = hit;
   end

   // Shift window, pattern capture and match pulse
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         window      <= '0;
         pattern_reg <= '0;
         match       <= 1'b0;
      end else begin
         match <= match_d;
         if (load) begin
            window      <= '0;
            pattern_reg <= pattern;
         end else if (bit_valid) begin
            window <= next_window;
         end
      end
   end

   assign armed = (state_q == ST_ARMED);

   // Count increments on the same edge that raises match
   sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_sat_counter (
      .clock    (clock),
      .clear    (clear),
      .inc      (hit),
      .sync_clr (load),
      .count    (match_count)
   );

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Self-checking bench for serial_pattern_detector: directed scenarios plus a
// randomized stream, two instances (8-bit and 2-bit counters) driven in parallel.
// Expected outputs come from a bit-history model of the detection rules.
module tb_serial_pattern_detector;

   logic       clock;
   logic       clear;
   logic       bit_in;
   logic       bit_valid;
   logic [3:0] pattern;
   logic       load;

   logic       match_a, match_b;
   logic [7:0] count_a;
   logic [1:0] count_b;
   logic [3:0] window_a, window_b;
   logic       armed_a, armed_b;

   int checks = 0;
   int errors = 0;

   serial_pattern_detector #(.WIDTH(4), .COUNT_W(8)) u_dut_a (
      .clock       (clock),
      .clear       (clear),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .pattern     (pattern),
      .load        (load),
      .match       (match_a),
      .match_count (count_a),
      .window      (window_a),
      .armed       (armed_a)
   );

   serial_pattern_detector #(.WIDTH(4), .COUNT_W(2)) u_dut_b (
      .clock       (clock),
      .clear       (clear),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .pattern     (pattern),
      .load        (load),
      .match       (match_b),
      .match_count (count_b),
      .window      (window_b),
      .armed       (armed_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: history of valid bits since reset/load
   int         hist[$];
   logic [3:0] pat_m;
   int         cnt_a_m, cnt_b_m;
   logic       match_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      pat_m   = 4'b0;
      cnt_a_m = 0;
      cnt_b_m = 0;
      match_m = 1'b0;
   endtask

   task automatic model_edge(input logic ld, input logic v, input logic b, input logic [3:0] p);
      bit is_hit;
      match_m = 1'b0;
      if (ld) begin
         pat_m = p;
         hist.delete();
         cnt_a_m = 0;
         cnt_b_m = 0;
      end else if (v) begin
         hist.push_back(int'(b));
         if (hist.size() >= 4) begin
            is_hit = 1'b1;
            for (int i = 0; i < 4; i++)
               if (hist[hist.size() - 4 + i] != int'(pat_m[3 - i])) is_hit = 1'b0;
            if (is_hit) begin
               match_m = 1'b1;
               if (cnt_a_m < 255) cnt_a_m++;
               if (cnt_b_m < 3)   cnt_b_m++;
            end
         end
      end
   endtask

   function automatic logic [3:0] exp_window();
      logic [3:0] w;
      int n;
      w = 4'b0;
      n = (hist.size() < 4) ? hist.size() : 4;
      for (int k = 0; k < n; k++) w[k] = hist[hist.size() - 1 - k][0];
      return w;
   endfunction

   task automatic compare_all();
      logic [3:0] w;
      logic       a;
      w = exp_window();
      a = (hist.size() >= 4);
      check("match_a",  {31'b0, match_a},  {31'b0, match_m});
      check("count_a",  {24'b0, count_a},  cnt_a_m);
      check("window_a", {28'b0, window_a}, {28'b0, w});
      check("armed_a",  {31'b0, armed_a},  {31'b0, a});
      check("match_b",  {31'b0, match_b},  {31'b0, match_m});
      check("count_b",  {30'b0, count_b},  cnt_b_m);
      check("window_b", {28'b0, window_b}, {28'b0, w});
      check("armed_b",  {31'b0, armed_b},  {31'b0, a});
   endtask

   // Drive one cycle, advance the model on the edge, compare just after it
   task automatic tick(input logic ld, input logic v, input logic b, input logic [3:0] p);
      load      = ld;
      bit_valid = v;
      bit_in    = b;
      pattern   = p;
      @(posedge clock);
      if (clear) model_edge(ld, v, b, p);
      #1;
      compare_all();
   endtask

   task automatic send_bits(input logic [6:0] bits, input int n);
      // bits[n-1] goes first
      for (int i = n - 1; i >= 0; i--) tick(1'b0, 1'b1, bits[i], 4'($urandom));
   endtask

   initial begin
      int nmatch;
      clear     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      pattern   = 4'b0;
      load      = 1'b0;
      model_reset();

      // Reset held with bit_valid toggling: everything stays zero
      for (int i = 0; i < 6; i++) tick(1'b0, 1'(i % 2), 1'b1, 4'hF);
      #2 clear = 1'b1;

      // First valid bit after reset lands in window[0]
      tick(1'b0, 1'b1, 1'b1, 4'h0);
      check("first_bit_lsb", {28'b0, window_a}, 32'h1);

      // Basic plus overlap: 1011 over stream 1,0,1,1,0,1,1
      tick(1'b1, 1'b0, 1'b0, 4'b1011);
      nmatch = 0;
      for (int i = 6; i >= 0; i--) begin
         logic [6:0] s;
         s = 7'b1011011;
         tick(1'b0, 1'b1, s[i], 4'h0);
         nmatch += int'(match_a);
      end
      check("basic_matches", nmatch, 2);
      check("basic_count", {24'b0, count_a}, 2);

      // Same stream with a 3-cycle gap between bits 2 and 3
      tick(1'b1, 1'b0, 1'b0, 4'b1011);
      send_bits(7'b0000010, 2);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b1, 4'h0);
         check("gap_window", {28'b0, window_a}, 32'h2);
      end
      send_bits(7'b0011011, 5);
      check("gap_count", {24'b0, count_a}, 2);

      // Load collides with a valid bit: bit discarded
      tick(1'b1, 1'b1, 1'b1, 4'b1011);
      check("collide_window", {28'b0, window_a}, 32'h0);
      check("collide_armed", {31'b0, armed_a}, 32'h0);
      send_bits(7'b0001011, 4);
      check("collide_match", {31'b0, match_a}, 32'h1);

      // Saturation: ten 1s against 1111
      tick(1'b1, 1'b0, 1'b0, 4'b1111);
      nmatch = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b1, 1'b1, 4'h0);
         nmatch += int'(match_b);
      end
      check("sat_pulses", nmatch, 7);
      check("sat_count_b", {30'b0, count_b}, 3);
      check("sat_count_a", {24'b0, count_a}, 7);

      // Async reset mid-stream, between edges
      send_bits(7'b0000011, 2);
      #2 clear = 1'b0;
      model_reset();
      #1;
      check("arst_window", {28'b0, window_a}, 32'h0);
      check("arst_count", {24'b0, count_a}, 32'h0);
      check("arst_match", {31'b0, match_a}, 32'h0);
      #1 clear = 1'b1;
      // Pattern is now 0: three zeros give nothing, the fourth matches
      nmatch = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b0, 4'h0);
         nmatch += int'(match_a);
      end
      check("arst_no_early", nmatch, 0);
      tick(1'b0, 1'b1, 1'b0, 4'h0);
      check("arst_fresh_match", {31'b0, match_a}, 32'h1);

      // Randomized stream with occasional loads and pattern noise
      for (int i = 0; i < 500; i++) begin
         tick(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom), 4'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
